// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin conditioning, frame FSM, E0/F0 prefix decode and
// a first-word-fall-through key FIFO. oKey = {break, extended, scancode}.
//
// state  | meaning
// IDLE   | waiting for a start bit (filtered data 0 on a clock fall)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then back to IDLE
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2Clk,
  input  logic       iPS2Data,
  input  logic       iRead,
  output logic [9:0] oKey,
  output logic       oValid,
  output logic       oFrameError,
  output logic       oOverflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic [FILTER_LEN-1:0] clk_sh_q, clk_sh_d, data_sh_q, data_sh_d;
  logic                  clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
  logic                  clk_prev_q;
  logic                  sample;

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  par_q, par_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  frame_good, frame_bad;

  logic                  brk_q, brk_d, ext_q, ext_d;
  logic                  push;
  logic [9:0]            wdata;

  logic [9:0]            mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, pop, push_ok;
  logic [9:0]            key_q, key_d;
  logic                  valid_q, ferr_q, ovf_q, ovf_d;

  // Input conditioning: a filtered level moves only when the whole window agrees.
  always_comb begin
    clk_sh_d  = {clk_sh_q[FILTER_LEN-2:0], clk_s2_q};
    data_sh_d = {data_sh_q[FILTER_LEN-2:0], data_s2_q};
    clk_filt_d  = clk_filt_q;
    data_filt_d = data_filt_q;
    if (&clk_sh_d)       clk_filt_d = 1'b1;
    else if (~|clk_sh_d) clk_filt_d = 1'b0;
    if (&data_sh_d)       data_filt_d = 1'b1;
    else if (~|data_sh_d) data_filt_d = 1'b0;
  end

  assign sample = clk_prev_q & ~clk_filt_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      data_s1_q   <= 1'b1;
      data_s2_q   <= 1'b1;
      clk_sh_q    <= '1;
      data_sh_q   <= '1;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_s1_q    <= iPS2Clk;
      clk_s2_q    <= clk_s1_q;
      data_s1_q   <= iPS2Data;
      data_s2_q   <= data_s1_q;
      clk_sh_q    <= clk_sh_d;
      data_sh_q   <= data_sh_d;
      clk_filt_q  <= clk_filt_d;
      data_filt_q <= data_filt_d;
      clk_prev_q  <= clk_filt_q;
    end
  end

  // Frame FSM; tmo_q is a down-counter reloaded on every sample event in a frame.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = tmo_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (state_q == IDLE) begin
      tmo_d = '0;
      if (sample && !data_filt_q) begin
        state_d   = DATA;
        bit_cnt_d = 3'd0;
        tmo_d     = TW'(TIMEOUT_CYCLES - 1);
      end
    end else if (sample) begin
      tmo_d = TW'(TIMEOUT_CYCLES - 1);
      case (state_q)
        DATA: begin
          shift_d   = {data_filt_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_filt_q;
          state_d = STOP;
        end
        default: begin
          if (data_filt_q && (^{shift_q, par_q})) frame_good = 1'b1;
          else                                   frame_bad  = 1'b1;
          state_d = IDLE;
          tmo_d   = '0;
        end
      endcase
    end else if (tmo_q == '0) begin
      frame_bad = 1'b1;
      state_d   = IDLE;
    end else begin
      tmo_d = tmo_q - TW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
    end
  end

  // Prefix decoder
  assign wdata = {brk_q, ext_q, shift_q};

  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    push  = 1'b0;
    if (frame_bad) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (frame_good) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  // Key FIFO; the head is precomputed so oKey is a plain register.
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = iRead & valid_q;
  assign push_ok = push & (~full | pop);
  assign ovf_d   = push & full & ~pop;

  always_comb begin
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    key_d = 10'h000;
    if (count_d != '0) begin
      if (push_ok && (rd_d == wr_q)) key_d = wdata;
      else                           key_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge Clock) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      key_q   <= 10'h000;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      key_q   <= key_d;
      valid_q <= (count_d != '0);
      ferr_q  <= frame_bad;
      ovf_q   <= ovf_d;
    end
  end

  assign oKey        = key_q;
  assign oValid      = valid_q;
  assign oFrameError = ferr_q;
  assign oOverflow   = ovf_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: bit-banged PS/2 frames, expected keys
// and pulse counts worked out by hand.
module tb_ps2_keyboard_rx;

  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd = 1'b0;
  logic [9:0] key;
  logic       valid, ferr, ovf;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  int ferr_cyc = 0;
  int last_fall = 0;
  int base_f, base_o;

  ps2_keyboard_rx #(.FILTER_LEN(8), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock(clk), .Reset(rst_n), .iPS2Clk(ps2_clk), .iPS2Data(ps2_data), .iRead(rd),
    .oKey(key), .oValid(valid), .oFrameError(ferr), .oOverflow(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ferr) begin
        ferr_cnt <= ferr_cnt + 1;
        ferr_cyc <= cyc;
      end
      if (ovf) ovf_cnt <= ovf_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit; optionally pulses iRead in the cycle the stop-bit event lands.
  task automatic send_bit(input logic b, input bit rd_pulse);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    last_fall = cyc;
    if (rd_pulse) begin
      tick(10);
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
      tick(9);
    end else begin
      tick(20);
    end
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit pflip, input logic stop, input bit rd_at_stop);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ pflip, 1'b0);
    send_bit(stop, rd_at_stop);
    ps2_data = 1'b1;
    tick(5);
  endtask

  task automatic pop_key();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  initial begin
    tick(3);
    check("rst_valid", valid, 0);
    check("rst_key", key, 10'h000);
    rst_n = 1'b1;
    tick(5);
    check("rst_ferr", ferr, 0);
    check("rst_ovf", ovf, 0);

    // Reset mid-frame after a break prefix
    base_f = ferr_cnt;
    send_frame(8'hF0, 0, 1, 0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    tick(2);
    check("midrst_valid", valid, 0);
    check("midrst_key", key, 10'h000);
    rst_n = 1'b1;
    tick(TMO + 40);
    check("midrst_no_ferr", ferr_cnt - base_f, 0);
    send_frame(8'h1C, 0, 1, 0);
    check("midrst_next_key", key, 10'h01C);
    pop_key();

    // Single key
    send_frame(8'h1C, 0, 1, 0);
    check("single_valid", valid, 1);
    check("single_key", key, 10'h01C);
    pop_key();
    check("single_pop_valid", valid, 0);
    check("single_pop_key", key, 10'h000);

    // Prefixes
    send_frame(8'hF0, 0, 1, 0);
    check("f0_alone_valid", valid, 0);
    send_frame(8'h1C, 0, 1, 0);
    check("brk_key", key, 10'h21C);
    pop_key();
    send_frame(8'hE0, 0, 1, 0);
    send_frame(8'hF0, 0, 1, 0);
    check("e0f0_alone_valid", valid, 0);
    send_frame(8'h75, 0, 1, 0);
    check("ext_brk_key", key, 10'h375);
    pop_key();
    send_frame(8'hE0, 0, 1, 0);
    send_frame(8'h75, 0, 1, 0);
    check("ext_key", key, 10'h175);
    pop_key();
    check("prefix_empty", valid, 0);

    // Frame errors
    base_f = ferr_cnt;
    send_frame(8'h1C, 1, 1, 0);
    check("parity_ferr", ferr_cnt - base_f, 1);
    check("parity_no_push", valid, 0);
    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h1C, 1, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    check("bad_clears_brk", key, 10'h01C);
    pop_key();
    base_f = ferr_cnt;
    send_frame(8'h1C, 0, 0, 0);
    check("stop_ferr", ferr_cnt - base_f, 1);
    check("stop_no_push", valid, 0);

    // Overflow
    base_o = ovf_cnt;
    for (int k = 1; k <= 8; k++) send_frame(8'(k), 0, 1, 0);
    check("fill_no_ovf", ovf_cnt - base_o, 0);
    send_frame(8'h09, 0, 1, 0);
    check("ovf_pulse", ovf_cnt - base_o, 1);
    check("ovf_head", key, 10'h001);

    // Full FIFO: push of 0x0A lands together with a pop of 0x001
    send_frame(8'h0A, 0, 1, 1);
    check("fullrw_no_ovf", ovf_cnt - base_o, 1);
    check("fullrw_head", key, 10'h002);
    for (int k = 2; k <= 8; k++) begin
      check("drain_key", key, 10'(k));
      pop_key();
    end
    check("drain_last", key, 10'h00A);
    check("drain_last_valid", valid, 1);
    pop_key();
    check("drained_valid", valid, 0);
    check("drained_key", key, 10'h000);

    // Timeout after start + 3 data bits
    base_f = ferr_cnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    tick(TMO + 40);
    check("tmo_ferr", ferr_cnt - base_f, 1);
    check("tmo_timing", ((ferr_cyc - last_fall) >= TMO + 6) && ((ferr_cyc - last_fall) <= TMO + 16), 1);
    check("tmo_no_push", valid, 0);
    send_frame(8'h1C, 0, 1, 0);
    check("tmo_next_key", key, 10'h01C);
    pop_key();

    // 5-cycle clock glitch with data low must not start a frame
    base_f = ferr_cnt;
    ps2_data = 1'b0;
    tick(12);
    ps2_clk = 1'b0;
    tick(5);
    ps2_clk = 1'b1;
    tick(12);
    ps2_data = 1'b1;
    tick(TMO + 40);
    check("glitch_no_ferr", ferr_cnt - base_f, 0);
    check("glitch_no_push", valid, 0);
    send_frame(8'h1C, 0, 1, 0);
    check("glitch_next_key", key, 10'h01C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives PS/2 keyboard frames and decodes the F0 (break) and E0 (extended) prefixes into one 10-bit key word per keystroke. Completed keys are buffered in a small first-word-fall-through FIFO. It sits directly upstream of the MiniAlu `TEC` instruction: `TEC` reads the head key into a register, and the core pops the FIFO once the word is consumed.

## Interface
- `FILTER_LEN`, 8: consecutive equal samples required before the filtered PS/2 clock or data changes level.
- `FIFO_DEPTH`, 8: key FIFO entries; must be a power of 2.
- `TIMEOUT_CYCLES`, 50000: maximum `Clock` cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 50 MHz).
- `Clock`  in  1  system clock, 50 MHz; everything is on its rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `iPS2Clk`  in  1  raw PS/2 clock pin; asynchronous to `Clock`.
- `iPS2Data`  in  1  raw PS/2 data pin; asynchronous to `Clock`.
- `iRead`  in  1  pop request for the FIFO head; ignored when `oValid`=0.
- `oKey`  out  10  FIFO head: {break, extended, scancode[7:0]}.
- `oValid`  out  1  FIFO not empty.
- `oFrameError`  out  1  one-cycle pulse when a frame is rejected.
- `oOverflow`  out  1  one-cycle pulse when a completed key is dropped because the FIFO is full.

## Operation
- **Input conditioning**
  - Each pin passes through a 2-flop synchronizer, then a FILTER_LEN shift filter.
  - A filtered level changes only when all FILTER_LEN samples agree; it holds otherwise.
  - Filtered levels reset to 1.
  - A sample event is a filtered-clock 1→0 transition; filtered data is sampled in that cycle.
- **Frame FSM**, states IDLE, DATA, PARITY, STOP:
  - IDLE: on a sample event with data=0 (start bit), go to DATA with bit count 0. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: shift the data LSB first; after the 8th bit, go to PARITY.
  - PARITY: latch the bit and go to STOP.
  - STOP: on a sample event, the frame is good if the stop bit is 1 and the ones count across data plus parity is odd. Either way, return to IDLE.
  - Timeout: in any non-IDLE state, a timeout counter counts cycles since the last sample event. On reaching TIMEOUT_CYCLES, the FSM returns to IDLE and the frame is treated as bad.
  - A bad frame (parity, stop or timeout) pulses `oFrameError`, discards the byte and clears both prefix flags.
- **Prefix decoder**, applied to each good byte:
  - 0xE0 sets the ext flag; 0xF0 sets the brk flag. Neither is pushed.
  - Any other byte pushes {brk, ext, byte}, then clears both flags.
- **FIFO**
  - `oKey` always shows the head entry; it is 0 when empty.
  - A push while full drops the key and pulses `oOverflow`. The prefix flags still clear.
  - `iRead` with `oValid`=1 pops the head.
  - Push and pop in the same cycle: both take effect, including when full (count unchanged, no overflow).
  - Push and `iRead` in the same cycle while empty: the push occurs and the read is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.

## Timing
- **Reset values**: `oKey`=0, `oValid`=0, `oFrameError`=0, `oOverflow`=0, FSM in IDLE, both prefix flags 0, FIFO empty, timeout counter 0.
- **Reset mid-frame**: the partial frame is abandoned and no pulse is produced.
- **Pin-to-event delay**: 2 synchronizer cycles plus FILTER_LEN cycles.
- **Key latency**: the key is visible on `oKey` with `oValid`=1 on the cycle after the stop-bit sample event.
- **Pulse timing**: `oFrameError` and `oOverflow` are asserted on that same cycle, for exactly 1 cycle.
- **Pop timing**: after a pop, the next entry (or 0 with `oValid`=0) appears on the following cycle.
- **All outputs are registered.**

## Test plan
- **Reset**: assert `Reset`=0 mid-frame, then release → `oValid`=0, `oKey`=10'h000, no pulses; the next good frame decodes normally.
- **Single key**: frame 0x1C with parity 0 and stop 1 → `oValid`=1, `oKey`=10'h01C; pulse `iRead` → `oValid`=0 the next cycle.
- **Prefixes**: frames F0,1C → `oKey`=10'h21C; frames E0,F0,75 → 10'h375; frames E0,75 → 10'h175. Prefix bytes alone leave `oValid`=0.
- **Frame errors**:
  - Frame 0x1C with parity 1 → `oFrameError` one-cycle pulse, nothing pushed.
  - Sequence F0, bad frame, 1C → `oKey`=10'h01C (brk flag was cleared).
  - Stop bit 0 → same pulse, nothing pushed.
- **Overflow**: 9 keys 0x01..0x09 with no reads → the 9th pulses `oOverflow`; 8 reads return 0x001..0x008 in order.
- **Full push/pop**: with the FIFO full, a push and `iRead` in the same cycle → no overflow and the count stays 8.
- **Timeout and glitch**:
  - Start bit plus 3 data bits, then the clock stays high → `oFrameError` TIMEOUT_CYCLES after the last edge, FSM back in IDLE; the following good frame 0x1C is accepted.
  - A 5-cycle low glitch on `iPS2Clk` → no sample event.
